// File: rtl/dds_pkg.sv
// Shared definitions for the DDS control blocks.
//   hop_state_e     : frequency-hop controller states
//   FTW_PER_KHZ_DEF : phase increment per kHz at fs = 1 GHz
//   FREQ_W_DEF      : internal kHz frequency width
//   KHZ_PER_MHZ     : MHz to kHz scale factor
package dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_DWELL
  } hop_state_e;

  localparam logic [31:0] FTW_PER_KHZ_DEF = 32'd4295;
  localparam int unsigned FREQ_W_DEF      = 26;
  localparam int unsigned KHZ_PER_MHZ     = 1000;

endpackage

// File: rtl/dds_prt_gen.sv
// PRT gate generator: free-running counter 0..cycle-1 with a width compare.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   en_i         : count and gate enable (gate forced low when 0)
//   clr_i        : restart counter at 0 (priority over en_i)
//   width_i      : pulse-high width in clocks
//   cycle_i      : period in clocks; 0 means CW (gate always high)
//   pulse_o      : gate output
module dds_prt_gen (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [31:0] width_i,
  input  logic [31:0] cycle_i,
  output logic        pulse_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cycle_i == '0 || cnt_q >= cycle_i - 32'd1) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // width >= cycle falls out as constant high since cnt never reaches cycle
  assign pulse_o = en_i && ((cycle_i == '0) || (cnt_q < width_i));

endmodule

// File: rtl/dds_hop_ctrl.sv
// Frequency-hop controller for a DDS: steps a kHz frequency from start to
// stop, converts it to a tuning word and gates the output with a PRT pulse.
//   clk_user_bufg / rst_glb       : clock, asynchronous active-high reset
//   hop_en_i                      : run request (level)
//   DDS_FREQHOP_START/STOP_MHz_VIO: hop range in MHz
//   DDS_FREQHOP_kHz_VIO           : hop step in kHz (0 = single frequency)
//   DDS_FREQHOPSPEED_VIO          : dwell per hop in clocks
//   DDS_PRT_WIDTH/CYCLE_VIO       : PRT pulse width and period in clocks
//   ftw_o / ftw_vld_o             : tuning word and one-cycle update strobe
//   pulse_o                       : PRT gate
//   hop_idx_o                     : hop index, 0 at start frequency
//   cfg_err_o                     : sticky start > stop flag
module dds_hop_ctrl
  import dds_pkg::*;
#(
  parameter logic [31:0] FTW_PER_KHZ = FTW_PER_KHZ_DEF,
  parameter int unsigned FREQ_W      = FREQ_W_DEF
) (
  input  logic        clk_user_bufg,
  input  logic        rst_glb,
  input  logic        hop_en_i,
  input  logic [15:0] DDS_FREQHOP_START_MHz_VIO,
  input  logic [15:0] DDS_FREQHOP_STOP_MHz_VIO,
  input  logic [15:0] DDS_FREQHOP_kHz_VIO,
  input  logic [31:0] DDS_FREQHOPSPEED_VIO,
  input  logic [31:0] DDS_PRT_WIDTH_VIO,
  input  logic [31:0] DDS_PRT_CYCLE_VIO,
  output logic [31:0] ftw_o,
  output logic        ftw_vld_o,
  output logic        pulse_o,
  output logic [15:0] hop_idx_o,
  output logic        cfg_err_o
);

  function automatic logic [FREQ_W-1:0] mhz_to_khz(input logic [15:0] mhz);
    return FREQ_W'(mhz) * FREQ_W'(KHZ_PER_MHZ);
  endfunction

  hop_state_e state_q, state_d;

  logic [15:0]       start_q, start_d, stop_q, stop_d, step_q, step_d;
  logic [31:0]       dwell_q, dwell_d, width_q, width_d, cycle_q, cycle_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [15:0]       hop_idx_q, hop_idx_d;
  logic [31:0]       dwell_cnt_q, dwell_cnt_d;
  logic [31:0]       prod_q, prod_d;
  logic              prod_pend_q, prod_pend_d;
  logic [31:0]       ftw_q, ftw_d;
  logic              ftw_vld_q, ftw_vld_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_bad, load_en, calc_en, hop_go, run_en, dwell_last;
  logic [31:0]       dwell_eff;
  logic [FREQ_W-1:0] next_khz;
  logic [31:0]       ftw_calc;

  assign cfg_bad    = DDS_FREQHOP_START_MHz_VIO > DDS_FREQHOP_STOP_MHz_VIO;
  assign dwell_eff  = (dwell_q == '0) ? 32'd1 : dwell_q;
  // The dwell count restarts at each frequency update and keeps running
  // through CALC, so frequency updates (and strobes) land exactly dwell
  // clocks apart; the CALC cycle bounds the hop period to at least 2.
  assign dwell_last = dwell_cnt_q >= (dwell_eff - 32'd1);
  assign next_khz   = freq_q + FREQ_W'(step_q);
  assign ftw_calc   = 32'(freq_q) * FTW_PER_KHZ;

  // State register
  always_ff @(posedge clk_user_bufg or posedge rst_glb) begin
    if (rst_glb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (hop_en_i && !cfg_err_q && !cfg_bad) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_CALC;
      ST_CALC:  state_d = ST_DWELL;
      ST_DWELL: if (dwell_last && step_q != '0) state_d = ST_CALC;
      default:  state_d = ST_IDLE;
    endcase
    if (!hop_en_i) state_d = ST_IDLE;
  end

  // FSM output decode; datapath updates are suppressed on the abort edge
  always_comb begin
    load_en = hop_en_i && (state_q == ST_LOAD);
    calc_en = hop_en_i && (state_q == ST_CALC);
    hop_go  = hop_en_i && (state_q == ST_DWELL) && dwell_last;
    run_en  = (state_q == ST_CALC) || (state_q == ST_DWELL);
  end

  always_comb begin
    start_d     = start_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    width_d     = width_q;
    cycle_d     = cycle_q;
    freq_d      = freq_q;
    hop_idx_d   = hop_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    prod_d      = prod_q;
    prod_pend_d = calc_en;
    ftw_d       = ftw_q;
    ftw_vld_d   = 1'b0;
    cfg_err_d   = cfg_err_q;

    if (load_en) begin
      start_d     = DDS_FREQHOP_START_MHz_VIO;
      stop_d      = DDS_FREQHOP_STOP_MHz_VIO;
      step_d      = DDS_FREQHOP_kHz_VIO;
      dwell_d     = DDS_FREQHOPSPEED_VIO;
      width_d     = DDS_PRT_WIDTH_VIO;
      cycle_d     = DDS_PRT_CYCLE_VIO;
      freq_d      = mhz_to_khz(DDS_FREQHOP_START_MHz_VIO);
      hop_idx_d   = '0;
      dwell_cnt_d = '0;
    end else if (hop_go) begin
      dwell_cnt_d = '0;
      if (step_q != '0) begin
        if (next_khz > mhz_to_khz(stop_q)) begin
          freq_d    = mhz_to_khz(start_q);
          hop_idx_d = '0;
        end else begin
          freq_d    = next_khz;
          hop_idx_d = hop_idx_q + 16'd1;
        end
      end
    end else if (run_en && hop_en_i) begin
      dwell_cnt_d = dwell_cnt_q + 32'd1;
    end

    if (calc_en) prod_d = ftw_calc;

    if (prod_pend_q && hop_en_i) begin
      ftw_d     = prod_q;
      ftw_vld_d = 1'b1;
    end

    if (!hop_en_i) begin
      cfg_err_d = 1'b0;
    end else if (state_q == ST_IDLE && cfg_bad) begin
      cfg_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_user_bufg or posedge rst_glb) begin
    if (rst_glb) begin
      start_q     <= '0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      width_q     <= '0;
      cycle_q     <= '0;
      freq_q      <= '0;
      hop_idx_q   <= '0;
      dwell_cnt_q <= '0;
      prod_q      <= '0;
      prod_pend_q <= 1'b0;
      ftw_q       <= '0;
      ftw_vld_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      start_q     <= start_d;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      width_q     <= width_d;
      cycle_q     <= cycle_d;
      freq_q      <= freq_d;
      hop_idx_q   <= hop_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      prod_q      <= prod_d;
      prod_pend_q <= prod_pend_d;
      ftw_q       <= ftw_d;
      ftw_vld_q   <= ftw_vld_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  dds_prt_gen u_prt_gen (
    .clk_i   (clk_user_bufg),
    .rst_i   (rst_glb),
    .en_i    (run_en),
    .clr_i   (load_en),
    .width_i (width_q),
    .cycle_i (cycle_q),
    .pulse_o (pulse_o)
  );

  assign ftw_o     = ftw_q;
  assign ftw_vld_o = ftw_vld_q;
  assign hop_idx_o = hop_idx_q;
  assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_dds_hop_ctrl.sv
// Self-checking bench for dds_hop_ctrl: directed and randomized runs checked
// cycle by cycle against an arithmetic model of the hop schedule and PRT gate.
module tb_dds_hop_ctrl;

  localparam longint unsigned FTW_K = 4295;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hop_en = 1'b0;
  logic [15:0] start_mhz = '0, stop_mhz = '0, step_khz = '0;
  logic [31:0] dwell = '0, prt_width = '0, prt_cycle = '0;
  logic [31:0] ftw;
  logic        ftw_vld, pulse, cfg_err;
  logic [15:0] hop_idx;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] hold_ftw = '0;
  logic [31:0] hold_idx = '0;

  dds_hop_ctrl #(.FTW_PER_KHZ(32'd4295), .FREQ_W(26)) dut (
    .clk_user_bufg             (clk),
    .rst_glb                   (rst),
    .hop_en_i                  (hop_en),
    .DDS_FREQHOP_START_MHz_VIO (start_mhz),
    .DDS_FREQHOP_STOP_MHz_VIO  (stop_mhz),
    .DDS_FREQHOP_kHz_VIO       (step_khz),
    .DDS_FREQHOPSPEED_VIO      (dwell),
    .DDS_PRT_WIDTH_VIO         (prt_width),
    .DDS_PRT_CYCLE_VIO         (prt_cycle),
    .ftw_o                     (ftw),
    .ftw_vld_o                 (ftw_vld),
    .pulse_o                   (pulse),
    .hop_idx_o                 (hop_idx),
    .cfg_err_o                 (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ftw_of(input int unsigned khz);
    longint unsigned p;
    p = longint'(khz) * FTW_K;
    return p[31:0];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag, input logic exp_err);
    check_val({tag, "_ftw"}, ftw, hold_ftw);
    check_val({tag, "_vld"}, 32'(ftw_vld), 32'd0);
    check_val({tag, "_pulse"}, 32'(pulse), 32'd0);
    check_val({tag, "_idx"}, 32'(hop_idx), hold_idx);
    check_val({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
  endtask

  // One run: hop_en high for len edges, then dropped and idle checked.
  // Edge e0 sees the request (LOAD); frequency j is applied on edge 1+j*P
  // and its tuning word strobes on edge 3+j*P, with P = max(dwell, 2).
  task automatic do_run(input int unsigned st, input int unsigned sp, input int unsigned stp,
                        input int unsigned dw, input int unsigned wd, input int unsigned cy,
                        input int len, input bit scramble);
    int unsigned fq[$];
    int unsigned ix[$];
    int unsigned nxt;
    int p, nj, j;
    logic [31:0] e_ftw, e_idx;
    logic e_vld, e_pul;

    p  = (dw < 2) ? 2 : int'(dw);
    nj = len / p + 2;
    fq.push_back(st * 1000);
    ix.push_back(0);
    for (int i = 1; i < nj; i++) begin
      nxt = fq[i-1] + stp;
      if (nxt > sp * 1000) begin
        fq.push_back(st * 1000);
        ix.push_back(0);
      end else begin
        fq.push_back(nxt);
        ix.push_back((ix[i-1] + 1) % 65536);
      end
    end

    start_mhz = 16'(st);  stop_mhz  = 16'(sp);  step_khz = 16'(stp);
    dwell     = dw;       prt_width = wd;       prt_cycle = cy;
    hop_en    = 1'b1;
    e_ftw = hold_ftw;
    e_idx = hold_idx;

    for (int k = 0; k < len; k++) begin
      next_cycle();
      if (k >= 3) begin
        j     = (stp == 0) ? 0 : (k - 3) / p;
        e_ftw = ftw_of(fq[j]);
        e_vld = ((k - 3) % p == 0) && (stp != 0 || k == 3);
      end else begin
        e_vld = 1'b0;
      end
      if (k >= 1) begin
        j     = (stp == 0) ? 0 : (k - 1) / p;
        e_idx = ix[j];
        e_pul = (cy == 0) || (((k - 1) % int'(cy)) < int'(wd));
      end else begin
        e_pul = 1'b0;
      end
      check_val("run_ftw", ftw, e_ftw);
      check_val("run_vld", 32'(ftw_vld), 32'(e_vld));
      check_val("run_idx", 32'(hop_idx), e_idx);
      check_val("run_pulse", 32'(pulse), 32'(e_pul));
      check_val("run_err", 32'(cfg_err), 32'd0);
      // shadowed config: live inputs may change freely after the latch edge
      if (scramble && k >= 1 && $urandom_range(0, 3) == 0) begin
        start_mhz = 16'($urandom);  stop_mhz  = 16'($urandom);
        step_khz  = 16'($urandom);  dwell     = $urandom_range(0, 9);
        prt_width = $urandom_range(0, 9); prt_cycle = $urandom_range(0, 9);
      end
    end

    hold_ftw = e_ftw;
    hold_idx = e_idx;
    hop_en   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      check_idle("abort", 1'b0);
    end
  endtask

  task automatic do_cfg_err(input int unsigned st, input int unsigned sp);
    start_mhz = 16'(st);
    stop_mhz  = 16'(sp);
    step_khz  = 16'd100;
    dwell     = 32'd3;
    hop_en    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      check_idle("cfgerr", 1'b1);
    end
    hop_en = 1'b0;
    next_cycle();
    check_idle("cfgclr", 1'b0);
  endtask

  task automatic do_reset_mid_calc();
    start_mhz = 16'd10;  stop_mhz  = 16'd12;  step_khz  = 16'd500;
    dwell     = 32'd4;   prt_width = 32'd3;   prt_cycle = 32'd10;
    hop_en    = 1'b1;
    next_cycle();   // LOAD
    next_cycle();   // CALC
    #1 rst = 1'b1;
    #1;
    hold_ftw = '0;
    hold_idx = '0;
    check_val("rst_async_ftw", ftw, 32'd0);
    check_val("rst_async_vld", 32'(ftw_vld), 32'd0);
    check_val("rst_async_pulse", 32'(pulse), 32'd0);
    check_val("rst_async_idx", 32'(hop_idx), 32'd0);
    check_val("rst_async_err", 32'(cfg_err), 32'd0);
    hop_en = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      check_idle("post_rst", 1'b0);
    end
  endtask

  initial begin
    int unsigned st, sp, stp;
    #1;
    check_val("reset_ftw", ftw, 32'd0);
    check_val("reset_vld", 32'(ftw_vld), 32'd0);
    check_val("reset_pulse", 32'(pulse), 32'd0);
    check_val("reset_idx", 32'(hop_idx), 32'd0);
    check_val("reset_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();

    // reference hop sequence 10..12 MHz, 500 kHz step, dwell 4, CW
    do_run(10, 12, 500, 4, 0, 0, 30, 1'b0);
    // single frequency, long hold, PRT 3/10
    do_run(10, 12, 0, 4, 3, 10, 1000, 1'b0);
    // PRT boundaries
    do_run(10, 10, 0, 4, 10, 10, 30, 1'b0);
    do_run(10, 10, 0, 4, 0, 10, 30, 1'b0);
    do_run(10, 10, 0, 4, 3, 10, 30, 1'b0);
    // dwell 0/1 and top-of-range truncated tuning words
    do_run(10, 11, 300, 0, 2, 5, 20, 1'b0);
    do_run(10, 11, 300, 1, 2, 5, 20, 1'b0);
    do_run(65534, 65535, 65535, 3, 1, 2, 25, 1'b0);
    // configuration error, then recovery
    do_cfg_err(20, 10);
    do_run(20, 20, 0, 2, 1, 3, 10, 1'b0);

    for (int r = 0; r < 40; r++) begin
      st  = ($urandom_range(0, 7) == 0) ? $urandom_range(65500, 65535) : $urandom_range(0, 200);
      sp  = st + $urandom_range(0, 3);
      if (sp > 65535) sp = 65535;
      stp = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 1500);
      do_run(st, sp, stp, $urandom_range(0, 6), $urandom_range(0, 12),
             $urandom_range(0, 12), int'($urandom_range(1, 60)), 1'b1);
      if (r % 10 == 5) do_cfg_err($urandom_range(101, 300), $urandom_range(0, 100));
    end

    do_reset_mid_calc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
